// File: rtl/cp_remover.sv
// Cyclic-prefix remover: drops CP_SIZE prefix samples per OFDM symbol and forwards
// the FFT_SIZE useful samples with per-symbol framing, symbol index and truncation flags.
module cp_remover #(
    parameter int FFT_SIZE = 1024,
    parameter int CP_SIZE  = 128,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic              o_eob,
    output logic [15:0]       o_sym_idx,
    output logic              err_trunc,
    output logic              dbg_state
);

    localparam int CP_W  = (CP_SIZE > 1) ? $clog2(CP_SIZE) : 1;
    localparam int CNT_W = $clog2(FFT_SIZE);

    typedef enum logic {
        S_CP   = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t           state;
    logic [CP_W-1:0]  cp_cnt;
    logic [CNT_W-1:0] dat_cnt;
    logic [15:0]      sym_idx;
    logic             in_fire;
    logic             cp_last;
    logic             dat_last;

    // Valid/ready: a beat moves on a port when valid and ready are both high at the
    // rising edge; once o_tvalid is high, o_tdata and sideband stay fixed until taken.
    // The prefix is swallowed regardless of downstream backpressure.
    assign i_tready  = (state == S_CP) || !o_tvalid || o_tready;
    assign in_fire   = i_tvalid && i_tready;
    assign cp_last   = (cp_cnt == CP_W'(CP_SIZE - 1));
    assign dat_last  = (dat_cnt == CNT_W'(FFT_SIZE - 1));
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_CP;
            cp_cnt    <= '0;
            dat_cnt   <= '0;
            sym_idx   <= '0;
            o_tdata   <= '0;
            o_tlast   <= 1'b0;
            o_tvalid  <= 1'b0;
            o_eob     <= 1'b0;
            o_sym_idx <= '0;
            err_trunc <= 1'b0;
        end else if (clear) begin
            state     <= S_CP;
            cp_cnt    <= '0;
            dat_cnt   <= '0;
            sym_idx   <= '0;
            o_tdata   <= '0;
            o_tlast   <= 1'b0;
            o_tvalid  <= 1'b0;
            o_eob     <= 1'b0;
            o_sym_idx <= '0;
            err_trunc <= 1'b0;
        end else begin
            err_trunc <= 1'b0;
            if (o_tvalid && o_tready) begin
                o_tvalid <= 1'b0;
            end
            case (state)
                S_CP: begin
                    if (in_fire) begin
                        if (i_tlast) begin
                            // Packet died inside the prefix: nothing to emit.
                            err_trunc <= 1'b1;
                            cp_cnt    <= '0;
                            sym_idx   <= '0;
                        end else if (cp_last) begin
                            cp_cnt  <= '0;
                            dat_cnt <= '0;
                            state   <= S_DATA;
                        end else begin
                            cp_cnt <= cp_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (in_fire) begin
                        o_tvalid  <= 1'b1;
                        o_tdata   <= i_tdata;
                        o_sym_idx <= sym_idx;
                        if (dat_last) begin
                            o_tlast <= 1'b1;
                            o_eob   <= i_tlast;
                            dat_cnt <= '0;
                            state   <= S_CP;
                            if (i_tlast) begin
                                sym_idx <= '0;
                            end else if (sym_idx != 16'hFFFF) begin
                                sym_idx <= sym_idx + 16'd1;
                            end
                        end else if (i_tlast) begin
                            // Short symbol: close it out and flag the packet as truncated.
                            o_tlast   <= 1'b1;
                            o_eob     <= 1'b1;
                            err_trunc <= 1'b1;
                            dat_cnt   <= '0;
                            sym_idx   <= '0;
                            state     <= S_CP;
                        end else begin
                            o_tlast <= 1'b0;
                            o_eob   <= 1'b0;
                            dat_cnt <= dat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_CP;
            endcase
        end
    end

endmodule

// File: tb/tb_cp_remover.sv
// Bench for cp_remover with FFT_SIZE=16, CP_SIZE=4: directed and randomized packets
// checked against a position-based model of which samples survive and how they are framed.
module tb_cp_remover;

    localparam int FFT    = 16;
    localparam int CP     = 4;
    localparam int SYM    = FFT + CP;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] i_tdata = '0;
    logic              i_tlast = 1'b0;
    logic              i_tvalid = 1'b0;
    logic              i_tready;
    logic [DATA_W-1:0] o_tdata;
    logic              o_tlast;
    logic              o_tvalid;
    logic              o_tready = 1'b1;
    logic              o_eob;
    logic [15:0]       o_sym_idx;
    logic              err_trunc;
    logic              dbg_state;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;
    bit ready_level = 1'b1;
    bit gaps = 1'b0;
    bit send_done = 1'b0;

    // Expected beat: {data, tlast, eob, sym_idx}
    logic [DATA_W+17:0] exp_q[$];

    cp_remover #(.FFT_SIZE(FFT), .CP_SIZE(CP), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_eob(o_eob), .o_sym_idx(o_sym_idx), .err_trunc(err_trunc), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        o_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Sample p of a packet of length L survives iff it is past the prefix of its symbol.
    task automatic model_packet(input logic [DATA_W-1:0] d[$], output int n_err);
        int len = d.size();
        for (int p = 0; p < len; p++) begin
            int s = p / SYM;
            int o = p % SYM;
            if (o >= CP) begin
                logic last = (o == SYM - 1) || (p == len - 1);
                logic eob = (p == len - 1);
                logic [15:0] idx = 16'(s);
                exp_q.push_back({d[p], last, eob, idx});
            end
        end
        n_err = (len % SYM != 0) ? 1 : 0;
    endtask

    task automatic send_beats(input logic [DATA_W-1:0] d[$], input bit with_last,
                              output int prefix_stalls);
        prefix_stalls = 0;
        for (int p = 0; p < d.size(); p++) begin
            int wait_cyc = 0;
            logic rdy = 1'b0;
            if (gaps) begin
                i_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            i_tvalid = 1'b1;
            i_tdata = d[p];
            i_tlast = with_last && (p == d.size() - 1);
            while (!rdy && wait_cyc < 1000) begin
                @(negedge clk);
                rdy = i_tready;
                if (!rdy && (p % SYM) < CP) prefix_stalls++;
                @(posedge clk);
                #1;
                wait_cyc++;
            end
            if (!rdy) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: sample %0d not accepted after %0d cycles, required acceptance", p, wait_cyc);
                break;
            end
        end
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
    endtask

    task automatic collect(input string name, output int n_err);
        logic hold = 1'b0;
        logic [DATA_W+17:0] held = '0;
        logic [DATA_W+17:0] cur;
        logic [DATA_W+17:0] exp_v;
        int cyc = 0;
        n_err = 0;
        while ((!send_done || exp_q.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            cur = {o_tdata, o_tlast, o_eob, o_sym_idx};
            if (err_trunc) n_err++;
            if (hold) begin
                checks++;
                if (cur !== held) begin
                    errors++;
                    $display("FAIL %s stall_hold: got %h, required %h", name, cur, held);
                end
            end
            if (o_tvalid && o_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_beat: got data=%h last=%b eob=%b idx=%0d, required no beat",
                             name, o_tdata, o_tlast, o_eob, o_sym_idx);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (cur !== exp_v) begin
                        errors++;
                        $display("FAIL %s beat: got data=%h last=%b eob=%b idx=%0d, required data=%h last=%b eob=%b idx=%0d",
                                 name, o_tdata, o_tlast, o_eob, o_sym_idx,
                                 exp_v[DATA_W+17:18], exp_v[17], exp_v[16], exp_v[15:0]);
                    end
                end
            end
            hold = o_tvalid && !o_tready;
            held = cur;
        end
        repeat (4) begin
            @(negedge clk);
            if (err_trunc) n_err++;
        end
        if (cyc >= 4000) begin
            checks++;
            errors++;
            $display("FAIL %s drain_timeout: %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_packet(input string name, input logic [DATA_W-1:0] d[$],
                              output int exp_err, output int got_err, output int stalls);
        model_packet(d, exp_err);
        send_done = 1'b0;
        fork
            begin
                send_beats(d, 1'b1, stalls);
                send_done = 1'b1;
            end
            collect(name, got_err);
        join
    endtask

    task automatic seq_packet(input int len, output logic [DATA_W-1:0] d[$]);
        d.delete();
        for (int i = 0; i < len; i++) d.push_back(DATA_W'(i));
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({o_tvalid, o_tlast, o_eob, err_trunc} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000", {o_tvalid, o_tlast, o_eob, err_trunc});
        end
        checks++;
        if (o_tdata !== '0 || o_sym_idx !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%h idx=%0d, required 0/0", o_tdata, o_sym_idx);
        end
        checks++;
        if (i_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", i_tready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_symbol();
        logic [DATA_W-1:0] d[$];
        int e, g, s;
        seq_packet(20, d);
        run_packet("single", d, e, g, s);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL single_err: got %0d pulses, required %0d", g, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d[$];
        int e, g, s;
        seq_packet(60, d);
        run_packet("back_to_back", d, e, g, s);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL back_to_back_err: got %0d pulses, required %0d", g, e);
        end
    endtask

    task automatic test_random_stall();
        logic [DATA_W-1:0] d[$];
        int e, g, s;
        for (int i = 0; i < 60; i++) d.push_back($urandom);
        rand_ready = 1'b1;
        run_packet("random_stall", d, e, g, s);
        rand_ready = 1'b0;
        checks++;
        if (s !== 0) begin
            errors++;
            $display("FAIL prefix_ready: got %0d stalled prefix beats, required 0", s);
        end
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL random_stall_err: got %0d pulses, required %0d", g, e);
        end
    endtask

    task automatic test_trunc_data();
        logic [DATA_W-1:0] d[$];
        int e, g, s;
        seq_packet(12, d);
        run_packet("trunc_data", d, e, g, s);
        checks++;
        if (g !== 1) begin
            errors++;
            $display("FAIL trunc_data_err: got %0d pulses, required 1", g);
        end
        seq_packet(20, d);
        run_packet("after_trunc_data", d, e, g, s);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL after_trunc_data_err: got %0d pulses, required %0d", g, e);
        end
    endtask

    task automatic test_trunc_prefix();
        logic [DATA_W-1:0] d[$];
        int e, g, s;
        seq_packet(3, d);
        run_packet("trunc_prefix", d, e, g, s);
        checks++;
        if (g !== 1) begin
            errors++;
            $display("FAIL trunc_prefix_err: got %0d pulses, required 1", g);
        end
        for (int i = 0; i < 20; i++) d[i] = $urandom;
        run_packet("after_trunc_prefix", d, e, g, s);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL after_trunc_prefix_err: got %0d pulses, required %0d", g, e);
        end
    endtask

    task automatic test_reset_mid_symbol();
        logic [DATA_W-1:0] d[$];
        int e, g, s;
        seq_packet(12, d);
        for (int i = CP; i < 12; i++) exp_q.push_back({DATA_W'(i), 1'b0, 1'b0, 16'd0});
        send_done = 1'b0;
        fork
            begin
                send_beats(d, 1'b0, s);
                send_done = 1'b1;
            end
            collect("pre_reset", g);
        join
        ready_level = 1'b0;
        @(posedge clk);
        #1;
        i_tdata = 32'd12;
        i_tvalid = 1'b1;
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 32'd12) begin
            errors++;
            $display("FAIL stalled_beat: got valid=%b data=%h, required 1/0000000c", o_tvalid, o_tdata);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: got o_tvalid=%b, required 0", o_tvalid);
        end
        checks++;
        if (i_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_mid: got %b, required 1", i_tready);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ready_level = 1'b1;
        @(posedge clk);
        #1;
        seq_packet(20, d);
        run_packet("post_reset", d, e, g, s);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL post_reset_err: got %0d pulses, required %0d", g, e);
        end
    endtask

    task automatic test_random_packets();
        logic [DATA_W-1:0] d[$];
        int e, g, s, len;
        gaps = 1'b1;
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d.delete();
            len = (k % 2 == 0) ? SYM * $urandom_range(1, 3) : $urandom_range(1, 70);
            for (int i = 0; i < len; i++) d.push_back($urandom);
            run_packet("random_packet", d, e, g, s);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL random_packet_err: len %0d got %0d pulses, required %0d", len, g, e);
            end
        end
        gaps = 1'b0;
        rand_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_random_stall();
        test_trunc_data();
        test_trunc_prefix();
        test_reset_mid_symbol();
        test_random_packets();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
